pe_dispatcher: RTL and testbench

Issue-side controller for one QR-decomposition PE. Accepts operand bundles (two complex samples plus two mode bits) on a valid/ready stream, launches the PE with a one-cycle trigger, and waits for the PE's finish pulse. It then captures the PE's four result words and mode bits into a 2-entry result buffer, which drains on a downstream valid/ready stream. A watchdog flags a PE that never finishes.

---
 rtl/qr_pkg.sv | 25 ++
 rtl/pe_result_fifo.sv | 62 ++++++
 rtl/pe_dispatcher.sv | 176 +++++++++++++++++
 tb/tb_pe_dispatcher.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/qr_pkg.sv
// Shared constants and types for the QR-decomposition PE issue path:
// mode encodings, dispatcher state encoding and the default result bundle.
package qr_pkg;

    localparam int DEF_DATA_W = 12;

    localparam logic M_VECTORING = 1'b1;
    localparam logic M_ROTATION  = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TRIG = 2'd1,
        ST_BUSY = 2'd2
    } state_e;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] real_x;
        logic [DEF_DATA_W-1:0] imag_x;
        logic [DEF_DATA_W-1:0] real_y;
        logic [DEF_DATA_W-1:0] imag_y;
        logic                  mode_x;
        logic                  mode_y;
    } result_t;

endpackage

// File: rtl/pe_result_fifo.sv
// Two-entry in-order result buffer. A push into a full buffer and a pop from
// an empty one are both dropped, so the occupancy count can never wrap.
module pe_result_fifo
    import qr_pkg::*;
#(
    parameter type entry_t = result_t
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_push,
    input  entry_t     i_push_data,
    input  logic       i_pop,
    output entry_t     o_head,
    output logic       o_valid,
    output logic [1:0] o_count
);

    localparam int DEPTH = 2;

    entry_t     mem_q [DEPTH];
    entry_t     mem_d [DEPTH];
    logic       wr_q, wr_d;
    logic       rd_q, rd_d;
    logic [1:0] count_q, count_d;
    logic       do_push, do_pop;

    // NOTE: every variable assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        do_push = i_push && (count_q != 2'(DEPTH));
        do_pop  = i_pop && (count_q != 2'd0);
        mem_d   = mem_q;
        if (do_push) begin
            mem_d[wr_q] = i_push_data;
        end
        wr_d    = wr_q ^ do_push;
        rd_d    = rd_q ^ do_pop;
        count_d = count_q + 2'(do_push) - 2'(do_pop);
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples values from before the clock edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: the storage is reset too, because the head is visible on the output ports and must read 0 after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            count_q <= 2'd0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    assign o_head  = mem_q[rd_q];
    assign o_valid = (count_q != 2'd0);
    assign o_count = count_q;

endmodule

// File: rtl/pe_dispatcher.sv
// Issue-side controller for one QR PE: accepts an operand bundle, triggers the
// PE, waits for finish (with a watchdog) and buffers results for downstream.
module pe_dispatcher
    import qr_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_real_x,
    input  logic [DATA_W-1:0] i_in_imag_x,
    input  logic [DATA_W-1:0] i_in_real_y,
    input  logic [DATA_W-1:0] i_in_imag_y,
    input  logic              i_in_mode_x,
    input  logic              i_in_mode_y,
    output logic              o_pe_trig,
    output logic [DATA_W-1:0] o_pe_real_x,
    output logic [DATA_W-1:0] o_pe_imag_x,
    output logic [DATA_W-1:0] o_pe_real_y,
    output logic [DATA_W-1:0] o_pe_imag_y,
    output logic              o_pe_mode_x,
    output logic              o_pe_mode_y,
    input  logic              i_pe_finish,
    input  logic [DATA_W-1:0] i_pe_real_x,
    input  logic [DATA_W-1:0] i_pe_imag_x,
    input  logic [DATA_W-1:0] i_pe_real_y,
    input  logic [DATA_W-1:0] i_pe_imag_y,
    input  logic              i_pe_mode_x,
    input  logic              i_pe_mode_y,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_real_x,
    output logic [DATA_W-1:0] o_out_imag_x,
    output logic [DATA_W-1:0] o_out_real_y,
    output logic [DATA_W-1:0] o_out_imag_y,
    output logic              o_out_mode_x,
    output logic              o_out_mode_y,
    output logic              o_busy,
    output logic              o_err,
    input  logic              i_err_clr,
    output logic [CNT_W-1:0]  o_done_cnt
);

    localparam int WD_W = $clog2(TIMEOUT);

    // Same shape as qr_pkg::result_t, but sized by this instance's DATA_W.
    typedef struct packed {
        logic [DATA_W-1:0] real_x;
        logic [DATA_W-1:0] imag_x;
        logic [DATA_W-1:0] real_y;
        logic [DATA_W-1:0] imag_y;
        logic              mode_x;
        logic              mode_y;
    } bundle_t;

    state_e           state_q, state_d;
    bundle_t          op_q, op_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic    accept, finish_ok, timeout;
    bundle_t pe_result, fifo_head;
    logic    fifo_valid;
    logic    fifo_pop;
    logic [1:0] fifo_count;

    assign accept    = i_in_valid && o_in_ready;
    assign finish_ok = (state_q == ST_BUSY) && i_pe_finish;
    // Finish beats the watchdog when both land in the same cycle.
    assign timeout   = (state_q == ST_BUSY) && !i_pe_finish && (wd_q == WD_W'(TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_TRIG;
            ST_TRIG: state_d = ST_BUSY;
            ST_BUSY: if (finish_ok || timeout) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_pe_trig  = (state_q == ST_TRIG);
        o_busy     = (state_q != ST_IDLE);
        o_in_ready = (state_q == ST_IDLE) && (fifo_count < 2'd2);
    end

    always_comb begin
        op_d = op_q;
        if (accept) begin
            op_d = '{real_x: i_in_real_x, imag_x: i_in_imag_x,
                     real_y: i_in_real_y, imag_y: i_in_imag_y,
                     mode_x: i_in_mode_x, mode_y: i_in_mode_y};
        end

        wd_d = wd_q;
        if (state_q == ST_TRIG) begin
            wd_d = '0;
        end else if (state_q == ST_BUSY) begin
            wd_d = wd_q + WD_W'(1);
        end

        err_d = err_q;
        if (timeout) begin
            err_d = 1'b1;
        end else if (i_err_clr) begin
            err_d = 1'b0;
        end

        cnt_d = finish_ok ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            op_q  <= '0;
            wd_q  <= '0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            op_q  <= op_d;
            wd_q  <= wd_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign pe_result = '{real_x: i_pe_real_x, imag_x: i_pe_imag_x,
                         real_y: i_pe_real_y, imag_y: i_pe_imag_y,
                         mode_x: i_pe_mode_x, mode_y: i_pe_mode_y};
    assign fifo_pop  = fifo_valid && i_out_ready;

    pe_result_fifo #(
        .entry_t (bundle_t)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (finish_ok),
        .i_push_data (pe_result),
        .i_pop       (fifo_pop),
        .o_head      (fifo_head),
        .o_valid     (fifo_valid),
        .o_count     (fifo_count)
    );

    assign o_pe_real_x  = op_q.real_x;
    assign o_pe_imag_x  = op_q.imag_x;
    assign o_pe_real_y  = op_q.real_y;
    assign o_pe_imag_y  = op_q.imag_y;
    assign o_pe_mode_x  = op_q.mode_x;
    assign o_pe_mode_y  = op_q.mode_y;

    assign o_out_valid  = fifo_valid;
    assign o_out_real_x = fifo_head.real_x;
    assign o_out_imag_x = fifo_head.imag_x;
    assign o_out_real_y = fifo_head.real_y;
    assign o_out_imag_y = fifo_head.imag_y;
    assign o_out_mode_x = fifo_head.mode_x;
    assign o_out_mode_y = fifo_head.mode_y;

    assign o_err      = err_q;
    assign o_done_cnt = cnt_q;

endmodule

// File: tb/tb_pe_dispatcher.sv
// Directed bench for pe_dispatcher with a PE stub that returns operand+1,
// echoes the modes and finishes a programmable number of cycles after trigger.
module tb_pe_dispatcher;
    import qr_pkg::*;

    localparam int DW = 12;
    localparam int TO = 64;
    localparam int CW = 16;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_rx, in_ix, in_ry, in_iy;
    logic          in_mx, in_my;
    logic          pe_trig;
    logic [DW-1:0] pe_rx, pe_ix, pe_ry, pe_iy;
    logic          pe_mx, pe_my;
    logic          stub_fin, spur_fin;
    logic [DW-1:0] stub_rx, stub_ix, stub_ry, stub_iy;
    logic          stub_mx, stub_my;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_rx, out_ix, out_ry, out_iy;
    logic          out_mx, out_my;
    logic          busy, err, err_clr;
    logic [CW-1:0] done_cnt;

    int  n_checks = 0;
    int  n_errors = 0;
    int  stub_lat = 14;
    int  stub_rem = 0;
    bit  stub_on  = 1'b1;
    logic [CW-1:0] exp_cnt = '0;

    pe_dispatcher #(.DATA_W(DW), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_in_real_x(in_rx), .i_in_imag_x(in_ix), .i_in_real_y(in_ry), .i_in_imag_y(in_iy),
        .i_in_mode_x(in_mx), .i_in_mode_y(in_my),
        .o_pe_trig(pe_trig),
        .o_pe_real_x(pe_rx), .o_pe_imag_x(pe_ix), .o_pe_real_y(pe_ry), .o_pe_imag_y(pe_iy),
        .o_pe_mode_x(pe_mx), .o_pe_mode_y(pe_my),
        .i_pe_finish(stub_fin | spur_fin),
        .i_pe_real_x(stub_rx), .i_pe_imag_x(stub_ix), .i_pe_real_y(stub_ry), .i_pe_imag_y(stub_iy),
        .i_pe_mode_x(stub_mx), .i_pe_mode_y(stub_my),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_real_x(out_rx), .o_out_imag_x(out_ix), .o_out_real_y(out_ry), .o_out_imag_y(out_iy),
        .o_out_mode_x(out_mx), .o_out_mode_y(out_my),
        .o_busy(busy), .o_err(err), .i_err_clr(err_clr), .o_done_cnt(done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Finish is raised mid-cycle so it is sampled exactly stub_lat+1 edges after the trigger cycle ends.
    always @(negedge clk) begin
        stub_fin = 1'b0;
        if (!rst_n) begin
            stub_rem = 0;
        end else if (stub_rem > 0) begin
            stub_rem = stub_rem - 1;
            if (stub_rem == 0) begin
                stub_fin = 1'b1;
                stub_rx  = pe_rx + 12'd1;
                stub_ix  = pe_ix + 12'd1;
                stub_ry  = pe_ry + 12'd1;
                stub_iy  = pe_iy + 12'd1;
                stub_mx  = pe_mx;
                stub_my  = pe_my;
            end
        end else if (pe_trig && stub_on) begin
            stub_rem = stub_lat + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [DW-1:0] rx, ix, ry, iy,
                             input logic mx, my);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_rx"}, 64'(out_rx), 64'(rx));
        check({tag, "_ix"}, 64'(out_ix), 64'(ix));
        check({tag, "_ry"}, 64'(out_ry), 64'(ry));
        check({tag, "_iy"}, 64'(out_iy), 64'(iy));
        check({tag, "_mode"}, 64'({out_mx, out_my}), 64'({mx, my}));
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Offers a bundle from a negedge; returns at the negedge inside the trigger cycle.
    task automatic send(input string tag, input logic [DW-1:0] rx, ix, ry, iy,
                        input logic mx, my);
        bit ok;
        ok = 1'b0;
        in_rx = rx; in_ix = ix; in_ry = ry; in_iy = iy; in_mx = mx; in_my = my;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_accepted"}, 64'(ok), 64'd1);
        check({tag, "_trig"}, 64'(pe_trig), 64'd1);
        check({tag, "_pe_rx"}, 64'(pe_rx), 64'(rx));
    endtask

    task automatic pop_one;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1, "bench time budget expired");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0; spur_fin = 1'b0;
        in_rx = '0; in_ix = '0; in_ry = '0; in_iy = '0; in_mx = 1'b0; in_my = 1'b0;
        stub_rx = '0; stub_ix = '0; stub_ry = '0; stub_iy = '0; stub_mx = 1'b0; stub_my = 1'b0;
        wait_cycles(2);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_vals", 64'({out_valid, pe_trig, busy, err, in_ready}), 64'b00001);
        check("reset_data", 64'({out_rx, pe_rx}), 64'd0);
        check("reset_cnt", 64'(done_cnt), 64'd0);

        // Single op, latency 14
        stub_lat = 14;
        send("op1", 12'h100, 12'h200, 12'h300, 12'h400, M_VECTORING, M_ROTATION);
        check("op1_busy", 64'(busy), 64'd1);
        check("op1_in_ready_low", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("op1_trig_one_cycle", 64'(pe_trig), 64'd0);
        wait_cycles(14);
        check("op1_not_yet_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check_out("op1_out", 12'h101, 12'h201, 12'h301, 12'h401, M_VECTORING, M_ROTATION);
        exp_cnt = exp_cnt + 1'b1;
        check("op1_cnt", 64'(done_cnt), 64'(exp_cnt));
        check("op1_idle", 64'({busy, in_ready}), 64'b01);
        pop_one();
        check("op1_popped", 64'(out_valid), 64'd0);

        // Backpressure: two results fill the buffer, third waits for a pop
        stub_lat = 2;
        send("bpA", 12'h011, 12'h022, 12'h033, 12'h044, M_ROTATION, M_VECTORING);
        wait_cycles(4);
        exp_cnt = exp_cnt + 1'b1;
        check("bpA_in_ready", 64'(in_ready), 64'd1);
        send("bpB", 12'hFFF, 12'h7FF, 12'h000, 12'h800, M_VECTORING, M_VECTORING);
        wait_cycles(4);
        exp_cnt = exp_cnt + 1'b1;
        check("bpB_full_in_ready", 64'(in_ready), 64'd0);
        check("bpB_cnt", 64'(done_cnt), 64'(exp_cnt));
        in_rx = 12'h123; in_ix = 12'h456; in_ry = 12'h789; in_iy = 12'hABC;
        in_mx = M_ROTATION; in_my = M_ROTATION;
        in_valid = 1'b1;
        wait_cycles(5);
        check("bpC_held_ready", 64'(in_ready), 64'd0);
        check("bpC_held_busy", 64'(busy), 64'd0);
        check("bpC_held_pe_rx", 64'(pe_rx), 64'hFFF);
        check_out("bp_head0", 12'h012, 12'h023, 12'h034, 12'h045, M_ROTATION, M_VECTORING);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_ready_after_pop", 64'(in_ready), 64'd1);
        check_out("bp_head1", 12'h000, 12'h800, 12'h001, 12'h801, M_VECTORING, M_VECTORING);
        @(negedge clk);
        in_valid = 1'b0;
        check("bpC_trig", 64'(pe_trig), 64'd1);
        check("bpC_pe_rx", 64'(pe_rx), 64'h123);
        wait_cycles(4);
        exp_cnt = exp_cnt + 1'b1;
        check("bpC_full_again", 64'(in_ready), 64'd0);
        check_out("bp_head1b", 12'h000, 12'h800, 12'h001, 12'h801, M_VECTORING, M_VECTORING);
        out_ready = 1'b1;
        @(negedge clk);
        check_out("bp_head2", 12'h124, 12'h457, 12'h78A, 12'hABD, M_ROTATION, M_ROTATION);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_drained", 64'(out_valid), 64'd0);
        check("bp_cnt", 64'(done_cnt), 64'(exp_cnt));

        // Watchdog timeout with a silent PE
        stub_on = 1'b0;
        send("to", 12'h0AB, 12'h0CD, 12'h0EF, 12'h012, M_VECTORING, M_VECTORING);
        wait_cycles(TO);
        check("to_err_before", 64'({err, busy}), 64'b01);
        @(negedge clk);
        check("to_err_raised", 64'(err), 64'd1);
        check("to_idle", 64'({busy, in_ready, out_valid}), 64'b010);
        check("to_cnt", 64'(done_cnt), 64'(exp_cnt));
        @(negedge clk);
        check("to_err_sticky", 64'(err), 64'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("to_err_cleared", 64'(err), 64'd0);
        stub_on = 1'b1;

        // Finish in the same cycle as the watchdog expiry
        stub_lat = TO - 1;
        send("tie", 12'h555, 12'h666, 12'h777, 12'h888, M_ROTATION, M_VECTORING);
        wait_cycles(TO + 1);
        exp_cnt = exp_cnt + 1'b1;
        check_out("tie_out", 12'h556, 12'h667, 12'h778, 12'h889, M_ROTATION, M_VECTORING);
        check("tie_err", 64'(err), 64'd0);
        check("tie_cnt", 64'(done_cnt), 64'(exp_cnt));
        pop_one();

        // Spurious finish in IDLE, then in TRIG
        spur_fin = 1'b1;
        @(negedge clk);
        spur_fin = 1'b0;
        check("spur_idle_nopush", 64'(out_valid), 64'd0);
        check("spur_idle_cnt", 64'(done_cnt), 64'(exp_cnt));
        stub_lat = 5;
        send("spur", 12'h0AA, 12'h0BB, 12'h0CC, 12'h0DD, M_VECTORING, M_ROTATION);
        spur_fin = 1'b1;
        @(negedge clk);
        spur_fin = 1'b0;
        check("spur_trig_ignored", 64'({out_valid, busy}), 64'b01);
        wait_cycles(6);
        exp_cnt = exp_cnt + 1'b1;
        check_out("spur_out", 12'h0AB, 12'h0BC, 12'h0CD, 12'h0DE, M_VECTORING, M_ROTATION);
        check("spur_cnt", 64'(done_cnt), 64'(exp_cnt));
        pop_one();
        check("spur_single_entry", 64'(out_valid), 64'd0);

        // Reset during BUSY with one result buffered
        stub_lat = 3;
        send("rstA", 12'h321, 12'h432, 12'h543, 12'h654, M_VECTORING, M_VECTORING);
        wait_cycles(5);
        check("rstA_buffered", 64'(out_valid), 64'd1);
        stub_lat = 20;
        send("rstB", 12'h111, 12'h222, 12'h333, 12'h444, M_ROTATION, M_ROTATION);
        wait_cycles(3);
        check("rstB_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_vals", 64'({out_valid, pe_trig, busy, err, in_ready}), 64'b00001);
        check("rst_async_cnt", 64'(done_cnt), 64'd0);
        wait_cycles(2);
        rst_n = 1'b1;
        @(negedge clk);
        exp_cnt = '0;
        check("rst_rel_vals", 64'({out_valid, busy, in_ready}), 64'b001);
        check("rst_rel_cnt", 64'(done_cnt), 64'(exp_cnt));
        check("rst_rel_data", 64'({out_rx, pe_rx}), 64'd0);

        stub_lat = 1;
        send("post", 12'h00F, 12'h0F0, 12'hF00, 12'h0FF, M_VECTORING, M_ROTATION);
        wait_cycles(3);
        exp_cnt = exp_cnt + 1'b1;
        check_out("post_out", 12'h010, 12'h0F1, 12'hF01, 12'h100, M_VECTORING, M_ROTATION);
        check("post_cnt", 64'(done_cnt), 64'(exp_cnt));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
